// File: rtl/dmem_ctrl.sv
// Handshaked byte-addressed data memory for the RV32 load/store path.
// Synchronous read with configurable latency, little-endian lanes, fault flags.
module dmem_ctrl #(
  parameter int unsigned DEPTH_BYTES  = 4096,
  parameter int unsigned READ_LATENCY = 1,
  parameter logic [2:0]  F3_LB        = 3'd0,
  parameter logic [2:0]  F3_LH        = 3'd1,
  parameter logic [2:0]  F3_LW        = 3'd2,
  parameter logic [2:0]  F3_LBU       = 3'd4,
  parameter logic [2:0]  F3_LHU       = 3'd5,
  parameter logic [2:0]  F3_SB        = 3'd0,
  parameter logic [2:0]  F3_SH        = 3'd1,
  parameter logic [2:0]  F3_SW        = 3'd2,
  localparam int unsigned MXLEN       = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [2:0]       req_funct3,
  input  logic [MXLEN-1:0] req_addr,
  input  logic [MXLEN-1:0] req_wdata,
  input  logic             exception,
  output logic             resp_valid,
  output logic [MXLEN-1:0] resp_rdata,
  output logic             load_misaligned,
  output logic             store_misaligned,
  output logic             access_fault
);

  localparam int unsigned AW = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
  localparam int unsigned XW = MXLEN + 2;
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t           state, state_next;
  logic [CW-1:0]    cnt, cnt_next;
  logic [MXLEN-1:0] load_buf, buf_next;
  logic [MXLEN-1:0] rdata_next;
  logic             lm_next, sm_next, af_next;
  logic             store_commit;

  logic [7:0]       mem [DEPTH_BYTES];

  // Request decode
  logic             is_lb, is_lh, is_lw, is_lbu, is_lhu, is_sb, is_sh, is_sw;
  logic             legal, is_half, is_word, misaligned, out_of_range, accept;
  logic [2:0]       size;
  logic [XW-1:0]    rd_idx;
  logic [31:0]      raw;
  logic [MXLEN-1:0] load_ext;

  always_comb begin
    is_lb   = !req_we && (req_funct3 == F3_LB);
    is_lh   = !req_we && (req_funct3 == F3_LH);
    is_lw   = !req_we && (req_funct3 == F3_LW);
    is_lbu  = !req_we && (req_funct3 == F3_LBU);
    is_lhu  = !req_we && (req_funct3 == F3_LHU);
    is_sb   =  req_we && (req_funct3 == F3_SB);
    is_sh   =  req_we && (req_funct3 == F3_SH);
    is_sw   =  req_we && (req_funct3 == F3_SW);
    legal   = is_lb | is_lh | is_lw | is_lbu | is_lhu | is_sb | is_sh | is_sw;
    is_half = is_lh | is_lhu | is_sh;
    is_word = is_lw | is_sw;
    size    = is_word ? 3'd4 : (is_half ? 3'd2 : 3'd1);
    misaligned   = (is_half && req_addr[0]) || (is_word && (req_addr[1:0] != 2'b00));
    // Widened compare so addresses near 2^32 cannot wrap into range
    out_of_range = (XW'(req_addr) + XW'(size)) > XW'(DEPTH_BYTES);
    accept  = req_valid && req_ready && !exception;
  end

  // Little-endian word at req_addr; bytes past the end of the array read as 0
  always_comb begin
    raw    = '0;
    rd_idx = '0;
    for (int k = 0; k < 4; k++) begin
      rd_idx = XW'(req_addr) + XW'(k);
      if (rd_idx < XW'(DEPTH_BYTES)) raw[8*k +: 8] = mem[AW'(rd_idx)];
    end
  end

  always_comb begin
    load_ext = raw;
    if (is_lb)       load_ext = {{(MXLEN-8){raw[7]}}, raw[7:0]};
    else if (is_lbu) load_ext = {{(MXLEN-8){1'b0}}, raw[7:0]};
    else if (is_lh)  load_ext = {{(MXLEN-16){raw[15]}}, raw[15:0]};
    else if (is_lhu) load_ext = {{(MXLEN-16){1'b0}}, raw[15:0]};
  end

  // Next-state and registered-output values
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    buf_next     = load_buf;
    rdata_next   = '0;
    lm_next      = 1'b0;
    sm_next      = 1'b0;
    af_next      = 1'b0;
    store_commit = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (misaligned) begin
            state_next = RESP;
            lm_next    = !req_we;
            sm_next    = req_we;
          end else if (out_of_range || !legal) begin
            state_next = RESP;
            af_next    = 1'b1;
          end else if (req_we) begin
            state_next   = RESP;
            store_commit = 1'b1;
          end else begin
            buf_next = load_ext;
            if (READ_LATENCY <= 1) begin
              state_next = RESP;
              rdata_next = load_ext;
            end else begin
              state_next = WAIT;
              cnt_next   = CW'(READ_LATENCY - 1);
            end
          end
        end
      end
      WAIT: begin
        if (exception) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt <= CW'(1)) begin
          state_next = RESP;
          cnt_next   = '0;
          rdata_next = load_buf;
        end else begin
          cnt_next = cnt - CW'(1);
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state            <= IDLE;
      cnt              <= '0;
      load_buf         <= '0;
      req_ready        <= 1'b1;
      resp_valid       <= 1'b0;
      resp_rdata       <= '0;
      load_misaligned  <= 1'b0;
      store_misaligned <= 1'b0;
      access_fault     <= 1'b0;
    end else begin
      state            <= state_next;
      cnt              <= cnt_next;
      load_buf         <= buf_next;
      req_ready        <= (state_next == IDLE);
      resp_valid       <= (state_next == RESP);
      resp_rdata       <= rdata_next;
      load_misaligned  <= lm_next;
      store_misaligned <= sm_next;
      access_fault     <= af_next;
    end
  end

  // Byte-lane store; array is deliberately not reset
  always_ff @(posedge CLK) begin
    if (store_commit && !RST) begin
      for (int k = 0; k < 4; k++) begin
        if (3'(k) < size) mem[AW'(req_addr + MXLEN'(k))] <= req_wdata[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Random and directed bench for dmem_ctrl: latency-1 and latency-3 instances
// share stimulus and are compared against a byte-array reference model.
module tb_dmem_ctrl;

  localparam int unsigned DEPTH = 1024;

  logic        clk, rst;
  logic        req_valid, req_we, exception;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;

  logic        rdy1, rv1, lm1, sm1, af1;
  logic [31:0] rd1;
  logic        rdy3, rv3, lm3, sm3, af3;
  logic [31:0] rd3;

  int checks = 0;
  int errors = 0;

  logic [7:0] mdl [DEPTH];

  dmem_ctrl #(.DEPTH_BYTES(DEPTH), .READ_LATENCY(1)) u_l1 (
    .CLK(clk), .RST(rst), .req_valid(req_valid), .req_ready(rdy1), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .exception(exception), .resp_valid(rv1), .resp_rdata(rd1),
    .load_misaligned(lm1), .store_misaligned(sm1), .access_fault(af1));

  dmem_ctrl #(.DEPTH_BYTES(DEPTH), .READ_LATENCY(3)) u_l3 (
    .CLK(clk), .RST(rst), .req_valid(req_valid), .req_ready(rdy3), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .exception(exception), .resp_valid(rv3), .resp_rdata(rd3),
    .load_misaligned(lm3), .store_misaligned(sm3), .access_fault(af3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference behaviour: returns the response a request should produce and
  // applies a clean store to the model array.
  function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, output logic [31:0] rd,
                                output logic lm, output logic sm, output logic af,
                                output bit clean_load);
    int size;
    bit legal;
    logic [31:0] w;
    rd = 0; lm = 0; sm = 0; af = 0; clean_load = 0;
    size = 1;
    legal = 1;
    if (we) begin
      case (f3)
        3'd0: size = 1;
        3'd1: size = 2;
        3'd2: size = 4;
        default: legal = 0;
      endcase
    end else begin
      case (f3)
        3'd0, 3'd4: size = 1;
        3'd1, 3'd5: size = 2;
        3'd2:       size = 4;
        default:    legal = 0;
      endcase
    end
    if (legal && size > 1 && (addr % size) != 0) begin
      if (we) sm = 1; else lm = 1;
    end else if (!legal || (longint'(addr) + longint'(size) > longint'(DEPTH))) begin
      af = 1;
    end else if (we) begin
      for (int k = 0; k < size; k++) mdl[addr + k] = wdata[8*k +: 8];
    end else begin
      clean_load = 1;
      w = 0;
      for (int k = 0; k < size; k++) w = w | (32'(mdl[addr + k]) << (8 * k));
      if (f3 == 3'd0 && w[7])  w = w | 32'hFFFF_FF00;
      if (f3 == 3'd1 && w[15]) w = w | 32'hFFFF_0000;
      rd = w;
    end
  endfunction

  // Expected {ready, valid, lm, sm, af, rdata} k cycles after the request edge.
  // mode: 0 normal, 1 exception with request, 2 exception next cycle, 3 reset next cycle
  function automatic logic [36:0] exp_vec(input int k, input int lat, input int mode,
                                          input logic [31:0] erd, input logic elm,
                                          input logic esm, input logic eaf);
    if (mode == 1 || (mode >= 2 && k >= 2)) return {1'b1, 36'b0};
    if (k == lat) return {1'b0, 1'b1, elm, esm, eaf, erd};
    return {(k > lat), 36'b0};
  endfunction

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input int mode, output logic [31:0] got_rd);
    logic [31:0] erd;
    logic elm, esm, eaf;
    bit cl;
    int lat3;
    got_rd = 0;
    if (mode == 1) begin
      erd = 0; elm = 0; esm = 0; eaf = 0; cl = 0;
    end else begin
      model(we, f3, addr, wdata, erd, elm, esm, eaf, cl);
    end
    lat3 = cl ? 3 : 1;
    req_valid = 1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    exception = (mode == 1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    exception = 0;
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("l1 k%0d a%h f%0d w%0d", k, addr, f3, we),
            64'({rdy1, rv1, lm1, sm1, af1, rd1}), 64'(exp_vec(k, 1, mode, erd, elm, esm, eaf)));
      check($sformatf("l3 k%0d a%h f%0d w%0d", k, addr, f3, we),
            64'({rdy3, rv3, lm3, sm3, af3, rd3}), 64'(exp_vec(k, lat3, mode, erd, elm, esm, eaf)));
      if (rv1) got_rd = rd1;
      if (k == 1 && mode == 2) exception = 1;
      if (k == 1 && mode == 3) rst = 1;
      if (k == 2) begin
        exception = 0;
        rst = 0;
      end
      @(negedge clk);
    end
  endtask

  logic [31:0] got;
  logic        r_we;
  logic [2:0]  r_f3;
  logic [31:0] r_addr;
  int          r_mode;

  initial begin
    rst = 1; req_valid = 0; req_we = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
    exception = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset l1", 64'({rdy1, rv1, lm1, sm1, af1, rd1}), 64'({1'b1, 36'b0}));
    check("reset l3", 64'({rdy3, rv3, lm3, sm3, af3, rd3}), 64'({1'b1, 36'b0}));
    rst = 0;
    @(negedge clk);

    for (int a = 0; a < DEPTH; a += 4) do_req(1, 3'd2, 32'(a), $urandom, 0, got);

    do_req(1, 3'd2, 32'h10, 32'h1122_3344, 0, got);
    do_req(0, 3'd2, 32'h10, 0, 0, got);  check("lw 0x10", 64'(got), 64'h1122_3344);
    do_req(0, 3'd4, 32'h10, 0, 0, got);  check("lbu 0x10", 64'(got), 64'h0000_0044);
    do_req(0, 3'd0, 32'h13, 0, 0, got);  check("lb 0x13", 64'(got), 64'h0000_0011);
    do_req(1, 3'd0, 32'h20, 32'h80, 0, got);
    do_req(0, 3'd0, 32'h20, 0, 0, got);  check("lb 0x20", 64'(got), 64'hFFFF_FF80);
    do_req(0, 3'd4, 32'h20, 0, 0, got);  check("lbu 0x20", 64'(got), 64'h0000_0080);
    do_req(1, 3'd1, 32'h22, 32'h8001, 0, got);
    do_req(0, 3'd1, 32'h22, 0, 0, got);  check("lh 0x22", 64'(got), 64'hFFFF_8001);
    do_req(0, 3'd5, 32'h22, 0, 0, got);  check("lhu 0x22", 64'(got), 64'h0000_8001);
    do_req(0, 3'd1, 32'h21, 0, 0, got);
    do_req(1, 3'd2, 32'h102, 32'hDEAD_BEEF, 0, got);
    do_req(0, 3'd2, 32'h100, 0, 0, got);
    do_req(1, 3'd2, 32'(DEPTH), 32'h1, 0, got);
    do_req(0, 3'd2, 32'(DEPTH - 2), 0, 0, got);
    do_req(0, 3'd1, 32'(DEPTH - 2), 0, 0, got);
    do_req(0, 3'd7, 32'h40, 0, 0, got);
    do_req(1, 3'd2, 32'hFFFF_FFFC, 32'h5, 0, got);
    do_req(1, 3'd2, 32'h10, 32'hCAFE_F00D, 1, got);
    do_req(0, 3'd2, 32'h10, 0, 0, got);  check("masked sw", 64'(got), 64'h1122_3344);
    do_req(0, 3'd2, 32'h10, 0, 2, got);
    do_req(0, 3'd2, 32'h14, 0, 3, got);
    do_req(1, 3'd2, 32'h18, 32'h0BAD_CAFE, 3, got);
    do_req(0, 3'd2, 32'h18, 0, 0, got);  check("sw before rst", 64'(got), 64'h0BAD_CAFE);

    for (int i = 0; i < 400; i++) begin
      r_we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) r_f3 = 3'($urandom_range(0, 7));
      else if (r_we) r_f3 = 3'($urandom_range(0, 2));
      else begin
        case ($urandom_range(0, 4))
          0: r_f3 = 3'd0;
          1: r_f3 = 3'd1;
          2: r_f3 = 3'd2;
          3: r_f3 = 3'd4;
          default: r_f3 = 3'd5;
        endcase
      end
      r_addr = 32'($urandom_range(0, DEPTH + 7));
      if ($urandom_range(0, 3) != 0) r_addr = r_addr & 32'hFFFF_FFFC;
      if ($urandom_range(0, 19) == 0) r_addr = 32'hFFFF_FFFC;
      case ($urandom_range(0, 19))
        0: r_mode = 1;
        1: r_mode = 2;
        2: r_mode = 3;
        default: r_mode = 0;
      endcase
      do_req(r_we, r_f3, r_addr, $urandom, r_mode, got);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Parametrised, handshaked data-memory controller for the RV32 core's load/store path.
- Successor to the combinational-read byte RAM. Adds a synchronous read with configurable latency and a valid/ready request handshake.
- Uses little-endian byte-lane stores.
- Detects misaligned and out-of-range accesses and reports each as a one-cycle exception flag alongside the response.

Parameters:
- DEPTH_BYTES, 4096: memory size in bytes; must be a multiple of 4.
- READ_LATENCY, 1: cycles from load accept to resp_valid; range 1..15.
- F3_LB/F3_LH/F3_LW/F3_LBU/F3_LHU, 0/1/2/4/5: load funct3 encodings.
- F3_SB/F3_SH/F3_SW, 0/1/2: store funct3 encodings.

Ports:
- CLK  in  1  clock
- RST  in  1  reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  access size/sign (F3_* encodings)
- req_addr  in  MXLEN  byte address
- req_wdata  in  MXLEN  store data, LSB-aligned
- exception  in  1  pipeline flush / trap in progress
- resp_valid  out  1  one-cycle response strobe
- resp_rdata  out  MXLEN  extended load data; 0 for stores and faults
- load_misaligned  out  1  qualified by resp_valid
- store_misaligned  out  1  qualified by resp_valid
- access_fault  out  1  qualified by resp_valid

Behaviour:
- Clocking and reset:
  - Single clock CLK.
  - Reset RST is synchronous and active-high.
  - On RST: state IDLE, wait counter 0, resp_valid 0, resp_rdata 0, all flags 0.
  - req_ready is 1 in the first cycle after reset.
  - Memory array contents are not reset.
- Accept rule:
  - A request is accepted on a rising edge where req_valid && req_ready && !exception.
  - req_ready = 1 only in IDLE.
  - With exception high, the request is dropped: no write, no response.
- States: IDLE, WAIT, RESP.
  - IDLE -> RESP on an accepted store, faulting access or illegal funct3.
  - IDLE -> WAIT on an accepted clean load with READ_LATENCY > 1; the counter is loaded with READ_LATENCY-1.
  - IDLE -> RESP directly on a clean load with READ_LATENCY = 1.
  - WAIT decrements the counter and moves to RESP when the counter reaches 1.
  - RESP drives resp_valid = 1 for exactly one cycle, then returns to IDLE.
  - A request cannot be accepted in RESP; back-to-back throughput is one request per READ_LATENCY+1 cycles for loads and one per 2 cycles for stores.
- Latency:
  - Loads: resp_valid is high READ_LATENCY cycles after the accept edge.
  - Stores, faults and illegal funct3: resp_valid is high 1 cycle after the accept edge.
- Flush during WAIT: exception high during WAIT aborts the load. The next state is IDLE, with no resp_valid and no flags.
- Fault checks, in priority order:
  1. Misaligned: H accesses with addr[0] != 0, or W accesses with addr[1:0] != 0. Raises load_misaligned or store_misaligned.
  2. Out of range: addr + size > DEPTH_BYTES, evaluated without 32-bit wrap. Raises access_fault.
  3. Illegal funct3: load funct3 of 3, 6 or 7; store funct3 >= 3. Raises access_fault.
  - Any fault: no memory write, resp_rdata = 0, exactly one flag high together with resp_valid.
- Stores:
  - Written on the accept edge, little-endian: byte k of req_wdata goes to mem[addr+k].
  - SB writes k = 0; SH writes k = 0..1; SW writes k = 0..3.
  - resp_rdata = 0.
- Loads:
  - The array is read at the accept edge into a registered buffer.
  - Assembly is little-endian: {mem[a+3], mem[a+2], mem[a+1], mem[a]}.
  - LB/LH sign-extend bit 7/15; LBU/LHU zero-extend.
  - resp_rdata holds its value only while resp_valid is high and is 0 otherwise.
- Flags: all flags are 0 whenever resp_valid is 0.
- Reset mid-operation: RST in WAIT or RESP returns to IDLE and suppresses any pending response. A store committed on an earlier edge remains in memory.

Test Plan:
- After reset, SW 0x11223344 @0x10, then LW @0x10 -> resp_rdata 0x11223344. LBU @0x10 -> 0x00000044. LB @0x13 -> 0x00000011.
- SB 0x80 @0x20, then LB @0x20 -> 0xFFFFFF80, LBU -> 0x00000080. SH 0x8001 @0x22, then LH @0x22 -> 0xFFFF8001, LHU -> 0x00008001.
- LH @0x21 -> load_misaligned=1, rdata 0. SW @0x102 -> store_misaligned=1; a following LW @0x100 shows the prior contents unchanged.
- SW @DEPTH_BYTES, and LW @DEPTH_BYTES-2 (which must raise misaligned, not fault) -> access_fault / load_misaligned respectively. LH @DEPTH_BYTES-2 succeeds. Load funct3=7 -> access_fault.
- READ_LATENCY=3: LW accepted at edge t -> req_ready=0 for cycles t+1..t+3, resp_valid high only at t+3. Repeat with exception high at t+1 -> no resp_valid, req_ready=1 at t+2.
- req_valid with exception high -> no write (verified by readback), no resp_valid. RST asserted during WAIT -> no resp_valid; req_ready=1 in the cycle after reset deasserts.
